mult_div_unit: RTL and testbench

Iterative 32-bit multiply/divide unit with HI/LO result registers for the MIPS datapath. It sits directly downstream of the register file: it consumes the two read ports (RdData1 → SrcA, RdData2 → SrcB) for MULT/MULTU/DIV/DIVU. It holds the 64-bit result in HI/LO for later MFHI/MFLO. It also accepts MTHI/MTLO writes from the same write-data bus that feeds the register file.

---
 rtl/mult_div_unit.sv | 126 ++++++++++++
 tb/tb_mult_div_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit with HI/LO result registers (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Signed ops run on magnitudes; sign fix-up is applied on the completion edge.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             HiWrEn,
  input  logic             LoWrEn,
  input  logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] acc_q, shr_q, b_q, hi_q, lo_q;
  logic             qneg_q, rneg_q, div0_q, busy_q, done_q;

  logic             sgn;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum, shifted;
  logic [WIDTH-1:0] acc_d, shr_d, quo, rem, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod, prod_s;

  // Operand magnitudes; op bit 0 selects unsigned, bit 1 selects divide.
  always_comb begin
    sgn   = ~Op[0];
    a_mag = (sgn && SrcA[WIDTH-1]) ? -SrcA : SrcA;
    b_mag = (sgn && SrcB[WIDTH-1]) ? -SrcB : SrcB;
  end

  // One iteration: shift-add (right shift) for multiply, restoring step (left shift) for divide.
  always_comb begin
    sum     = {1'b0, acc_q} + (shr_q[0] ? {1'b0, b_q} : '0);
    shifted = {acc_q, shr_q[WIDTH-1]};
    acc_d   = sum[WIDTH:1];
    shr_d   = {sum[0], shr_q[WIDTH-1:1]};
    if (op_q[1]) begin
      if (shifted >= {1'b0, b_q}) begin
        acc_d = WIDTH'(shifted - {1'b0, b_q});
        shr_d = {shr_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = shifted[WIDTH-1:0];
        shr_d = {shr_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Final result from the last iteration's output; divide-by-zero forces an all-ones quotient.
  always_comb begin
    prod   = {acc_d, shr_d};
    prod_s = qneg_q ? -prod : prod;
    quo    = div0_q ? '1 : (qneg_q ? -shr_d : shr_d);
    rem    = rneg_q ? -acc_d : acc_d;
    res_hi = op_q[1] ? rem : prod_s[2*WIDTH-1:WIDTH];
    res_lo = op_q[1] ? quo : prod_s[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      shr_q   <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            op_q    <= Op;
            acc_q   <= '0;
            shr_q   <= a_mag;
            b_q     <= b_mag;
            qneg_q  <= sgn && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            rneg_q  <= sgn && SrcA[WIDTH-1];
            div0_q  <= Op[1] && (SrcB == '0);
          end else begin
            if (HiWrEn) hi_q <= WrData;
            if (LoWrEn) lo_q <= WrData;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          shr_q <= shr_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= res_hi;
            lo_q    <= res_lo;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Hi   = hi_q;
  assign Lo   = lo_q;
  assign Busy = busy_q;
  assign Done = done_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit; inputs driven and outputs sampled on the falling edge.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        rst, Start, HiWrEn, LoWrEn, Busy, Done;
  logic [1:0]  Op;
  logic [31:0] SrcA, SrcB, WrData, Hi, Lo;
  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
    .HiWrEn(HiWrEn), .LoWrEn(LoWrEn), .WrData(WrData),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge right after the accept edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; SrcA = a; SrcB = b;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
  endtask

  // Waits for Done with a bound; 'already' is the number of edges since the accept edge.
  task automatic wait_done(input string tag, input int already,
                           input logic [31:0] ehi, input logic [31:0] elo);
    int n = already;
    int busy_bad = 0;
    while (!Done && n < 40) begin
      if (Busy !== 1'b1) busy_bad++;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 64'(n), 64'd32);
    chk({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
    chk({tag, "_hi"}, {32'd0, Hi}, {32'd0, ehi});
    chk({tag, "_lo"}, {32'd0, Lo}, {32'd0, elo});
    chk({tag, "_busy_end"}, {63'd0, Busy}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    start_op(op, a, b);
    chk({tag, "_busy_start"}, {63'd0, Busy}, 64'd1);
    wait_done(tag, 0, ehi, elo);
    @(negedge clk);
    chk({tag, "_done_clr"}, {63'd0, Done}, 64'd0);
  endtask

  initial begin
    int dn;
    rst = 1'b1; Start = 1'b0; Op = 2'b00; SrcA = '0; SrcB = '0;
    HiWrEn = 1'b0; LoWrEn = 1'b0; WrData = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_hi", {32'd0, Hi}, 64'd0);
    chk("rst_lo", {32'd0, Lo}, 64'd0);
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_done", {63'd0, Done}, 64'd0);

    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg",  2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("div_neg",   2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu",      2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E);
    run_op("divu_z",    2'b11, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF);
    run_op("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("div_z_neg", 2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);

    // MTHI in idle lands next edge without a Done pulse
    HiWrEn = 1'b1; WrData = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    HiWrEn = 1'b0;
    chk("mthi_hi", {32'd0, Hi}, 64'hDEADBEEF);
    chk("mthi_done", {63'd0, Done}, 64'd0);

    // Running MULTU 6x7: new Start, Op change and MTHI mid-run are all ignored
    start_op(2'b01, 32'd6, 32'd7);
    repeat (4) begin @(posedge clk); @(negedge clk); end
    Start = 1'b1; Op = 2'b10; SrcA = 32'd99; SrcB = 32'd3;
    HiWrEn = 1'b1; WrData = 32'h0BADF00D;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0; HiWrEn = 1'b0;
    chk("ign_hi_hold", {32'd0, Hi}, 64'hDEADBEEF);
    wait_done("ign", 5, 32'd0, 32'd42);
    @(negedge clk);

    // Simultaneous MTHI/MTLO
    HiWrEn = 1'b1; LoWrEn = 1'b1; WrData = 32'hA5A5_0001;
    @(posedge clk);
    @(negedge clk);
    HiWrEn = 1'b0; LoWrEn = 1'b0;
    chk("mt_both_hi", {32'd0, Hi}, 64'hA5A50001);
    chk("mt_both_lo", {32'd0, Lo}, 64'hA5A50001);

    // Start wins over MTLO in the same cycle; Lo holds old value during the run
    LoWrEn = 1'b1; WrData = 32'h11111111;
    start_op(2'b11, 32'd100, 32'd7);
    LoWrEn = 1'b0;
    chk("start_pri_lo", {32'd0, Lo}, 64'hA5A50001);
    wait_done("start_pri", 0, 32'd2, 32'd14);

    // Back-to-back: new Start in the Done cycle
    start_op(2'b01, 32'd6, 32'd7);
    chk("b2b_done", {63'd0, Done}, 64'd0);
    chk("b2b_busy", {63'd0, Busy}, 64'd1);
    wait_done("b2b", 0, 32'd0, 32'd42);
    @(negedge clk);

    // Reset mid-operation aborts with no Done pulse
    start_op(2'b11, 32'd100, 32'd7);
    repeat (9) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", {63'd0, Busy}, 64'd0);
    chk("mid_rst_hi", {32'd0, Hi}, 64'd0);
    chk("mid_rst_lo", {32'd0, Lo}, 64'd0);
    dn = 0;
    repeat (36) begin
      if (Done !== 1'b0) dn++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_rst_no_done", 64'(dn), 64'd0);
    run_op("after_rst", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
